// File: rtl/csr_spi_bridge.sv
// Byte-stream to CSR bridge: command, address and data bytes from the SPI byte layer become CSR strobes.
// Define CSR_SPI_BRIDGE_ERR_EN to build the sticky overrun flag on err_o (otherwise err_o is tied 0).
module csr_spi_bridge #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_BYTES   = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_rst_i,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_pop_i,
  output logic [7:0]                tx_data_o,
  output logic                      tx_load_o,
  output logic [ADDR_WIDTH-1:0]     csr_addr_o,
  output logic [8*DATA_BYTES-1:0]   csr_wdata_o,
  output logic                      csr_we_o,
  output logic                      csr_re_o,
  input  logic [8*DATA_BYTES-1:0]   csr_rdata_i,
  output logic                      err_o
);

  localparam int DW         = 8 * DATA_BYTES;
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] WORD_LAST = 3'(DATA_BYTES - 1);
  localparam logic [2:0] WORD_FULL = 3'(DATA_BYTES);
  localparam logic [2:0] WAIT_DONE = 3'(READ_LATENCY);

  typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_WDATA, ST_RWAIT, ST_RDATA} state_t;

  state_t          state_reg, state_next;
  logic            write_reg, hold_reg;
  logic [2:0]      byte_cnt_reg, wait_cnt_reg;
  logic [DW-1:0]   wbuf_reg, rbuf_reg;

  logic            clr, pop;
  logic            addr_done, word_done, capture, rd_next_byte, rd_word_end;
  logic            we_set, re_set, load_set;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DW-1:0]   word_shift;

  // A frame abort behaves exactly like reset, and it beats a coincident pop.
  assign clr = rst | spi_rst_i;
  assign pop = rx_pop_i & ~clr;

  // Shifting left by a byte naturally discards address bits above ADDR_WIDTH.
  assign addr_shift = (csr_addr_o << 8) | ADDR_WIDTH'(rx_data_i);
  assign word_shift = (wbuf_reg << 8) | DW'(rx_data_i);

  always_ff @(posedge clk) begin
    if (clr) state_reg <= ST_CMD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CMD:   if (pop)         state_next = ST_ADDR;
      ST_ADDR:  if (addr_done)   state_next = write_reg ? ST_WDATA : ST_RWAIT;
      ST_RWAIT: if (capture)     state_next = ST_RDATA;
      ST_RDATA: if (rd_word_end) state_next = ST_RWAIT;
      default:  ;
    endcase
  end

  always_comb begin
    addr_done    = 1'b0;
    word_done    = 1'b0;
    capture      = 1'b0;
    rd_next_byte = 1'b0;
    rd_word_end  = 1'b0;
    case (state_reg)
      ST_ADDR:  addr_done = pop && (byte_cnt_reg == ADDR_LAST);
      ST_WDATA: word_done = pop && (byte_cnt_reg == WORD_LAST);
      ST_RWAIT: capture   = (wait_cnt_reg == WAIT_DONE);
      ST_RDATA: begin
        // byte_cnt_reg holds how many bytes of the word were already handed to tx
        rd_word_end  = pop && (byte_cnt_reg == WORD_FULL);
        rd_next_byte = pop && (byte_cnt_reg != WORD_FULL);
      end
      default: ;
    endcase
    we_set   = word_done;
    re_set   = (addr_done && !write_reg) || rd_word_end;
    load_set = capture || rd_next_byte;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      write_reg    <= 1'b0;
      hold_reg     <= 1'b0;
      byte_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      wbuf_reg     <= '0;
      rbuf_reg     <= '0;
      csr_addr_o   <= '0;
      csr_wdata_o  <= '0;
      csr_we_o     <= 1'b0;
      csr_re_o     <= 1'b0;
      tx_data_o    <= '0;
      tx_load_o    <= 1'b0;
    end else begin
      csr_we_o     <= we_set;
      csr_re_o     <= re_set;
      tx_load_o    <= load_set;
      wait_cnt_reg <= (state_reg == ST_RWAIT) ? wait_cnt_reg + 3'd1 : 3'd0;
      if (state_reg == ST_CMD && pop) begin
        write_reg    <= rx_data_i[7];
        hold_reg     <= rx_data_i[6];
        byte_cnt_reg <= '0;
      end
      if (state_reg == ST_ADDR && pop) begin
        csr_addr_o   <= addr_shift;
        byte_cnt_reg <= addr_done ? 3'd0 : byte_cnt_reg + 3'd1;
      end
      if (state_reg == ST_WDATA && pop) begin
        wbuf_reg     <= word_shift;
        byte_cnt_reg <= word_done ? 3'd0 : byte_cnt_reg + 3'd1;
        if (word_done) csr_wdata_o <= word_shift;
      end
      // Write address advances after its strobe; read address advances with the next strobe.
      if (csr_we_o && !hold_reg) csr_addr_o <= csr_addr_o + ADDR_WIDTH'(1);
      if (rd_word_end && !hold_reg) csr_addr_o <= csr_addr_o + ADDR_WIDTH'(1);
      if (capture) begin
        tx_data_o    <= csr_rdata_i[DW-1 -: 8];
        rbuf_reg     <= csr_rdata_i << 8;
        byte_cnt_reg <= 3'd1;
      end
      if (rd_next_byte) begin
        tx_data_o    <= rbuf_reg[DW-1 -: 8];
        rbuf_reg     <= rbuf_reg << 8;
        byte_cnt_reg <= byte_cnt_reg + 3'd1;
      end
    end
  end

`ifdef CSR_SPI_BRIDGE_ERR_EN
  logic overrun;
  logic err_reg;
  assign overrun = (state_reg == ST_RWAIT) && pop;

  // Survives frame aborts so the host can poll it later.
  always_ff @(posedge clk) begin
    if (rst)          err_reg <= 1'b0;
    else if (overrun) err_reg <= 1'b1;
  end
  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

endmodule
